// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory responder.
// Holds the responder FSM state encoding, default geometry, the byte-to-word
// index offset, and a helper that flags misaligned word accesses.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DATA_W_DEF     = 32;
  localparam int DEPTH_LOG2_DEF = 7;

  // Word index starts at byte-address bit 2, matching instruction-memory indexing.
  localparam int WORD_IDX_LSB   = 2;

  // A word access is misaligned when either low byte-address bit is set.
  function automatic logic is_misaligned(input logic [WORD_IDX_LSB-1:0] low_bits);
    return (low_bits != '0);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM stage and the data-memory responder.
//   master : pipeline side, drives req_*, observes req_ready/resp_*/stall
//   slave  : responder side, the mirror image
interface dmem_responder_if #(
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_write;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              stall;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, stall
  );
endinterface

// File: rtl/dmem_array.sv
// Single-port word RAM backing the data memory.
// Synchronous write and synchronous read; rdata keeps its last value on
// cycles without a read. Contents are never cleared.
//   CLK   : clock
//   we    : write enable, stores wdata at idx
//   re    : read enable, loads mem[idx] into rdata
//   idx   : word index
//   wdata : write data
//   rdata : registered read data
module dmem_array #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 7
) (
  input  logic                  CLK,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge CLK) begin
    if (we) mem[idx] <= wdata;
    if (re) rdata    <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle handshaked data memory for the MEM stage of the 5-stage MIPS
// pipeline. One access outstanding at a time; the pipeline is stalled while
// a request is pending and no response is being delivered.
//   CLK   : clock
//   reset : synchronous active-high reset (aborts any access not yet committed)
//   bus   : request/response bundle (slave side)
// Parameters: DATA_W word width, DEPTH_LOG2 log2 words, LATENCY wait cycles (0..15).
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int LATENCY    = 2
) (
  input  logic             CLK,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int          AW      = DEPTH_LOG2 + WORD_IDX_LSB;
  localparam logic [3:0]  LAT_CNT = 4'(LATENCY);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              load_sel_q, load_sel_d;
  logic              err_q, err_d;

  // Fields of the access being committed this cycle; with LATENCY=0 they
  // come straight from the request port instead of the latched copy.
  logic              commit;
  logic              acc_wr;
  logic [AW-1:0]     acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_mis;

  logic              ram_we, ram_re;
  logic [DATA_W-1:0] ram_rdata;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    load_sel_d = load_sel_q;
    err_d      = err_q;
    commit     = 1'b0;
    acc_wr     = wr_q;
    acc_addr   = addr_q;
    acc_wdata  = wdata_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          wr_d    = bus.req_write;
          addr_d  = bus.req_addr[AW-1:0];
          wdata_d = bus.req_wdata;
          if (LATENCY == 0) begin
            state_d   = RESP;
            commit    = 1'b1;
            acc_wr    = bus.req_write;
            acc_addr  = bus.req_addr[AW-1:0];
            acc_wdata = bus.req_wdata;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_CNT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP: begin
        // The pipeline advances on this edge, so the held request is not re-accepted.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    acc_mis = is_misaligned(acc_addr[WORD_IDX_LSB-1:0]);

    // Response attributes are captured at the commit edge and held until the next one.
    if (commit) begin
      load_sel_d = ~acc_wr & ~acc_mis;
      err_d      = acc_mis;
    end
  end

  // A reset sampled on the commit edge must suppress the array access too.
  assign ram_we = commit & acc_wr  & ~acc_mis & ~reset;
  assign ram_re = commit & ~acc_wr & ~acc_mis & ~reset;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      load_sel_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      load_sel_q <= load_sel_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge CLK) begin
    wr_q    <= wr_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  dmem_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .CLK   (CLK),
    .we    (ram_we),
    .re    (ram_re),
    .idx   (acc_addr[AW-1:WORD_IDX_LSB]),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

  // RAM output holds between reads; stores and faults present zero instead.
  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = load_sel_q ? ram_rdata : '0;
  assign bus.resp_err   = err_q;
  assign bus.stall      = bus.req_valid & ~bus.resp_valid;

endmodule
